// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RV32 data-memory stage (funct3 codes, FSM states, pipeline structs).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dmem_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } acc_size_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_to_reg;
      logic [31:0] alu_output;
   } mem_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_to_reg;
      logic [31:0] alu_output;
      logic [31:0] final_out;
   } wback_state_t;

   // Access width from funct3; the unused codes (011/110/111) fall back to a word access.
   function automatic acc_size_t size_of(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: size_of = SZ_B;
         F3_H, F3_HU: size_of = SZ_H;
         default:     size_of = SZ_W;
      endcase
   endfunction

   // Byte enables; half/word ignore the low address bits that would make them misaligned.
   function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] a);
      case (size_of(funct3))
         SZ_B:    be_gen = 4'b0001 << a;
         SZ_H:    be_gen = 4'b0011 << {a[1], 1'b0};
         default: be_gen = 4'b1111;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] a);
      case (size_of(funct3))
         SZ_B:    misaligned = 1'b0;
         SZ_H:    misaligned = a[0];
         default: misaligned = (a != 2'b00);
      endcase
   endfunction

   function automatic wback_state_t wb_pack(input mem_state_t m, input logic reg_write,
                                            input logic [31:0] final_out);
      wback_state_t w;
      w.pc         = m.pc;
      w.rd         = m.rd;
      w.reg_write  = reg_write;
      w.mem_to_reg = m.mem_to_reg;
      w.alu_output = m.alu_output;
      w.final_out  = final_out;
      return w;
   endfunction

endpackage

// File: rtl/dmem_align.sv
// Store lane replication / byte enables and load byte/half extraction with sign or zero extension.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the outputs are used.
module dmem_align
   import dmem_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_addr,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_lanes,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Store side: replicate the byte/half into every lane so the enables alone select the target.
   always_comb begin
      st_be = be_gen(st_funct3, st_addr);
      case (size_of(st_funct3))
         SZ_B:    st_lanes = {4{st_data[7:0]}};
         SZ_H:    st_lanes = {2{st_data[15:0]}};
         default: st_lanes = st_data;
      endcase
   end

   // Load side: pick the addressed lane then extend; unused codes read as a full word.
   always_comb begin
      ld_byte = ld_rdata[{ld_addr, 3'b000} +: 8];
      ld_half = ld_addr[1] ? ld_rdata[31:16] : ld_rdata[15:0];
      case (ld_funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_BU:   ld_data = {24'h0, ld_byte};
         F3_HU:   ld_data = {16'h0, ld_half};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// RV32 MEM stage: drives a req/gnt/rvalid word memory, registers MEM->WB, watchdog aborts hung accesses.
// Latency: store completes in the gnt cycle, load in the rvalid cycle; WB register updates on the next edge.
// Backpressure: o_stall holds IF..MEM until completion; DMEM_MISALIGN_TRAP_EN adds o_misalign trapping.
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 2048,
   parameter int WADDR_WIDTH = $clog2(DEPTH),
   parameter int TIMEOUT     = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  mem_state_t             i_mem_state,
   input  logic                   i_req_valid,
   input  logic                   i_we,
   input  logic [2:0]             i_funct3,
   input  logic [31:0]            i_addr,
   input  logic [31:0]            i_wdata,
   output logic                   o_stall,
   output wback_state_t           o_wback_state,
   output logic                   o_mem_req,
   output logic                   o_mem_we,
   output logic [WADDR_WIDTH-1:0] o_mem_addr,
   output logic [3:0]             o_mem_be,
   output logic [31:0]            o_mem_wdata,
   input  logic                   i_mem_gnt,
   input  logic                   i_mem_rvalid,
   input  logic [31:0]            i_mem_rdata,
   output logic                   o_bus_err
`ifdef DMEM_MISALIGN_TRAP_EN
   ,
   output logic                   o_misalign
`endif
);

   localparam int CW = $clog2(TIMEOUT + 1);

   lsu_state_t     state;
   logic [CW-1:0]  wd_cnt;
   mem_state_t     lat_state;
   logic           lat_we;
   logic [2:0]     lat_funct3;
   logic [1:0]     lat_addr_lo;

   logic           abort;
   logic           done_ok;
   logic           trap;
   logic [3:0]     st_be;
   logic [31:0]    st_lanes;
   logic [31:0]    ld_data;

   // Address bits above the memory window do not reach the memory port.
   logic           addr_hi_unused;
   assign addr_hi_unused = ^i_addr[31:WADDR_WIDTH+2];

   dmem_align u_align (
      .st_funct3 (i_funct3),
      .st_addr   (i_addr[1:0]),
      .st_data   (i_wdata),
      .st_be     (st_be),
      .st_lanes  (st_lanes),
      .ld_funct3 (lat_funct3),
      .ld_addr   (lat_addr_lo),
      .ld_rdata  (i_mem_rdata),
      .ld_data   (ld_data)
   );

   // Completion/abort decode and the combinational stall; the watchdog wins over a same-cycle response.
   always_comb begin
      abort   = (state != IDLE) && (wd_cnt == CW'(TIMEOUT));
      done_ok = 1'b0;
      if (!abort) begin
         case (state)
            REQ:     done_ok = i_mem_gnt && (lat_we || i_mem_rvalid);
            RESP:    done_ok = i_mem_rvalid;
            default: done_ok = 1'b0;
         endcase
      end
`ifdef DMEM_MISALIGN_TRAP_EN
      trap = (state == IDLE) && i_req_valid && misaligned(i_funct3, i_addr[1:0]);
`else
      trap = 1'b0;
`endif
      if (state == IDLE) o_stall = i_req_valid && !trap;
      else               o_stall = !(done_ok || abort);
   end

   // Access FSM, memory port registers, watchdog and the MEM/WB register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state         <= IDLE;
         wd_cnt        <= '0;
         lat_state     <= '0;
         lat_we        <= 1'b0;
         lat_funct3    <= '0;
         lat_addr_lo   <= '0;
         o_wback_state <= '0;
         o_mem_req     <= 1'b0;
         o_mem_we      <= 1'b0;
         o_mem_addr    <= '0;
         o_mem_be      <= '0;
         o_mem_wdata   <= '0;
         o_bus_err     <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
         o_misalign    <= 1'b0;
`endif
      end else begin
         o_bus_err <= abort;
`ifdef DMEM_MISALIGN_TRAP_EN
         o_misalign <= trap;
`endif
         if (abort)
            o_wback_state <= wb_pack(lat_state, 1'b0, lat_state.alu_output);
         else if (done_ok)
            o_wback_state <= wb_pack(lat_state, lat_state.reg_write,
                                     lat_we ? lat_state.alu_output : ld_data);
         else if (o_stall)
            o_wback_state <= '0;
         else
            o_wback_state <= wb_pack(i_mem_state, i_mem_state.reg_write && !trap,
                                     i_mem_state.alu_output);

         case (state)
            IDLE: begin
               if (i_req_valid && !trap) begin
                  state       <= REQ;
                  wd_cnt      <= '0;
                  lat_state   <= i_mem_state;
                  lat_we      <= i_we;
                  lat_funct3  <= i_funct3;
                  lat_addr_lo <= i_addr[1:0];
                  o_mem_req   <= 1'b1;
                  o_mem_we    <= i_we;
                  o_mem_addr  <= i_addr[WADDR_WIDTH+1:2];
                  o_mem_be    <= i_we ? st_be : 4'b0000;
                  o_mem_wdata <= i_we ? st_lanes : 32'h0;
               end
            end
            REQ: begin
               if (abort || done_ok) begin
                  state     <= IDLE;
                  wd_cnt    <= '0;
                  o_mem_req <= 1'b0;
                  o_mem_we  <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
                  if (i_mem_gnt) begin
                     state     <= RESP;
                     o_mem_req <= 1'b0;
                     o_mem_we  <= 1'b0;
                  end
               end
            end
            RESP: begin
               if (abort || done_ok) begin
                  state  <= IDLE;
                  wd_cnt <= '0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu against a byte-addressed memory model plus directed corner cases.
// Latency: drives one access at a time, checks every stall/bubble cycle and the WB result.
// Backpressure: the bench plays the memory, choosing gnt/rvalid delays (or none, to hit the watchdog).
module tb_dmem_lsu;
   import dmem_pkg::*;

   localparam int TIMEOUT = 16;
   localparam int WAW     = 11;

   logic         i_clk;
   logic         i_reset;
   mem_state_t   i_mem_state;
   logic         i_req_valid;
   logic         i_we;
   logic [2:0]   i_funct3;
   logic [31:0]  i_addr;
   logic [31:0]  i_wdata;
   logic         o_stall;
   wback_state_t o_wback_state;
   logic         o_mem_req;
   logic         o_mem_we;
   logic [WAW-1:0] o_mem_addr;
   logic [3:0]   o_mem_be;
   logic [31:0]  o_mem_wdata;
   logic         i_mem_gnt;
   logic         i_mem_rvalid;
   logic [31:0]  i_mem_rdata;
   logic         o_bus_err;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic         o_misalign;
`endif

   dmem_lsu #(.DEPTH(2048), .TIMEOUT(TIMEOUT)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_mem_state   (i_mem_state),
      .i_req_valid   (i_req_valid),
      .i_we          (i_we),
      .i_funct3      (i_funct3),
      .i_addr        (i_addr),
      .i_wdata       (i_wdata),
      .o_stall       (o_stall),
      .o_wback_state (o_wback_state),
      .o_mem_req     (o_mem_req),
      .o_mem_we      (o_mem_we),
      .o_mem_addr    (o_mem_addr),
      .o_mem_be      (o_mem_be),
      .o_mem_wdata   (o_mem_wdata),
      .i_mem_gnt     (i_mem_gnt),
      .i_mem_rvalid  (i_mem_rvalid),
      .i_mem_rdata   (i_mem_rdata),
      .o_bus_err     (o_bus_err)
`ifdef DMEM_MISALIGN_TRAP_EN
      ,
      .o_misalign    (o_misalign)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Device memory the DUT talks to, and the reference byte array the expectations come from.
   logic [31:0] dev_mem [0:2047];
   logic [7:0]  ref_mem [0:8191];

   logic [3:0]  cap_be;
   logic [31:0] cap_lanes;
   logic [31:0] cap_addr;
   int          cap_stall_n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic poke(input int w, input logic [31:0] v);
      dev_mem[w] = v;
      for (int i = 0; i < 4; i++) ref_mem[w*4 + i] = v[8*i +: 8];
   endtask

   // One memory instruction; gnt_dly/rv_dly are REQ-relative cycle numbers (>= TIMEOUT means never).
   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                            output logic [31:0] fin);
      mem_state_t  ms;
      int          nb;
      int          base;
      logic [31:0] exp_val;
      logic [3:0]  exp_be;
      logic [31:0] exp_lanes;
      logic        mis;
      logic        done;
      logic        aborted;
      logic        end_now;
      nb        = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      mis       = (int'(addr[1:0]) % nb) != 0;
      base      = int'(addr[12:0]) - (int'(addr[12:0]) % nb);
      exp_be    = 4'(((1 << nb) - 1) << (base % 4));
      for (int i = 0; i < 4; i++) exp_lanes[8*i +: 8] = wdata[8*(i % nb) +: 8];
      exp_val = 32'h0;
      for (int i = 0; i < nb; i++) exp_val = exp_val | (32'(ref_mem[base + i]) << (8*i));
      if (nb < 4 && (f3 == 3'd0 || f3 == 3'd1) && exp_val[8*nb-1])
         exp_val = exp_val - (32'd1 << (8*nb));
      ms.pc         = $urandom;
      ms.rd         = 5'($urandom_range(1, 31));
      ms.reg_write  = !we;
      ms.mem_to_reg = !we;
      ms.alu_output = addr;
      fin           = 32'h0;
      cap_stall_n   = 0;

      @(negedge i_clk);
      i_req_valid  = 1'b1;
      i_we         = we;
      i_funct3     = f3;
      i_addr       = addr;
      i_wdata      = wdata;
      i_mem_state  = ms;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      #1;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (mis) begin
         chk("trap_stall", o_stall, 1'b0);
         @(negedge i_clk);
         i_req_valid = 1'b0;
         #1;
         chk("trap_pulse", o_misalign, 1'b1);
         chk("trap_noreq", o_mem_req, 1'b0);
         chk("trap_rw", o_wback_state.reg_write, 1'b0);
         chk("trap_pc", o_wback_state.pc, ms.pc);
         @(negedge i_clk);
         #1;
         chk("trap_pulse_end", o_misalign, 1'b0);
         return;
      end
`endif
      chk("idle_stall", o_stall, 1'b1);
      if (o_stall) cap_stall_n++;
      done    = 1'b0;
      aborted = 1'b0;
      for (int k = 0; k <= TIMEOUT && !done; k++) begin
         @(negedge i_clk);
         i_mem_gnt    = (k == gnt_dly);
         i_mem_rvalid = !we && (k == rv_dly);
         i_mem_rdata  = i_mem_rvalid ? dev_mem[o_mem_addr] : $urandom;
         #1;
         chk("bubble_rw", o_wback_state.reg_write, 1'b0);
         chk("bubble_rd", o_wback_state.rd, 5'd0);
         chk("mem_req", o_mem_req, k <= gnt_dly);
         if (k == 0) begin
            cap_be    = o_mem_be;
            cap_lanes = o_mem_wdata;
            cap_addr  = 32'(o_mem_addr);
            chk("mem_addr", o_mem_addr, addr[12:2]);
            chk("mem_we", o_mem_we, we);
            if (we) begin
               chk("mem_be", o_mem_be, exp_be);
               chk("mem_wdata", o_mem_wdata, exp_lanes);
            end
         end
         end_now = (k == TIMEOUT) || (we ? (k == gnt_dly) : (k == rv_dly));
         chk("stall", o_stall, !end_now);
         if (o_stall) cap_stall_n++;
         if (we && i_mem_gnt && k < TIMEOUT)
            for (int i = 0; i < 4; i++)
               if (o_mem_be[i]) dev_mem[o_mem_addr][8*i +: 8] = o_mem_wdata[8*i +: 8];
         if (end_now) begin
            done    = 1'b1;
            aborted = (k == TIMEOUT);
         end
      end
      @(negedge i_clk);
      i_req_valid  = 1'b0;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      #1;
      chk("bus_err", o_bus_err, aborted);
      chk("req_drop", o_mem_req, 1'b0);
      chk("wb_pc", o_wback_state.pc, ms.pc);
      chk("wb_rd", o_wback_state.rd, ms.rd);
      chk("wb_rw", o_wback_state.reg_write, aborted ? 1'b0 : ms.reg_write);
      fin = o_wback_state.final_out;
      if (!aborted && !we) chk("ld_data", o_wback_state.final_out, exp_val);
      if (!aborted && we)
         for (int i = 0; i < nb; i++) ref_mem[base + i] = wdata[8*i +: 8];
   endtask

   // Non-memory instruction: must pass straight into WB with its ALU result.
   task automatic do_alu();
      mem_state_t ms;
      ms.pc         = $urandom;
      ms.rd         = 5'($urandom);
      ms.reg_write  = 1'($urandom);
      ms.mem_to_reg = 1'b0;
      ms.alu_output = $urandom;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      i_mem_state = ms;
      #1;
      chk("alu_stall", o_stall, 1'b0);
      @(negedge i_clk);
      #1;
      chk("alu_final", o_wback_state.final_out, ms.alu_output);
      chk("alu_rw", o_wback_state.reg_write, ms.reg_write);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [31:0] fin;
      mem_state_t  ms2;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          g;
      int          r;
      logic [2:0]  st_f3 [6];
      st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
      for (int w = 0; w < 2048; w++) poke(w, $urandom);

      i_reset      = 1'b1;
      i_req_valid  = 1'b0;
      i_we         = 1'b0;
      i_funct3     = 3'd0;
      i_addr       = 32'h0;
      i_wdata      = 32'h0;
      i_mem_state  = '0;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = 32'h0;
      repeat (3) @(negedge i_clk);
      #1;
      chk("rst_wb_pc", o_wback_state.pc, 32'h0);
      chk("rst_wb_rw", o_wback_state.reg_write, 1'b0);
      chk("rst_req", o_mem_req, 1'b0);
      chk("rst_we", o_mem_we, 1'b0);
      chk("rst_bus_err", o_bus_err, 1'b0);
      chk("rst_stall", o_stall, 1'b0);
      @(negedge i_clk);
      i_reset = 1'b0;

      // Directed cases.
      do_access(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00AB, 0, 99, fin);
      chk("sb_be_lit", cap_be, 4'b1000);
      chk("sb_wdata_lit", cap_lanes, 32'hABAB_ABAB);
      chk("sb_addr_lit", cap_addr, 32'h40);
      chk("sb_stall_cycles", cap_stall_n, 1);
      poke(32'h40, 32'h0080_0000);
      do_access(1'b0, 3'd0, 32'h0000_0102, 32'h0, 2, 3, fin);
      chk("lb_lit", fin, 32'hFFFF_FF80);
      do_access(1'b0, 3'd4, 32'h0000_0102, 32'h0, 2, 3, fin);
      chk("lbu_lit", fin, 32'h0000_0080);
      poke(0, 32'h8001_FFFF);
      do_access(1'b0, 3'd1, 32'h0000_0002, 32'h0, 1, 4, fin);
      chk("lh_lit", fin, 32'hFFFF_8001);
      chk("lh_stall_cycles", cap_stall_n, 5);
      do_access(1'b0, 3'd0, 32'h0000_0003, 32'h0, 0, 0, fin);
      chk("same_cycle_gnt_rvalid", fin, 32'hFFFF_FF80);
      poke(0, 32'h1234_5678);
      do_access(1'b0, 3'd2, 32'h0000_0001, 32'h0, 0, 1, fin);
`ifndef DMEM_MISALIGN_TRAP_EN
      chk("lw_misalign_forced", fin, 32'h1234_5678);
      chk("lw_misalign_addr", cap_addr, 32'h0);
`endif

      // Watchdog: load that never sees rvalid, store that never sees gnt.
      do_access(1'b0, 3'd2, 32'h0000_0010, 32'h0, 0, 99, fin);
      @(negedge i_clk);
      #1;
      chk("bus_err_pulse_end", o_bus_err, 1'b0);
      do_access(1'b1, 3'd2, 32'h0000_0020, 32'hDEAD_BEEF, 99, 99, fin);
      do_access(1'b0, 3'd2, 32'h0000_0020, 32'h0, 1, 2, fin);
      do_alu();

      // Reset while waiting in RESP, then a stray rvalid in IDLE.
      @(negedge i_clk);
      i_req_valid = 1'b1;
      i_we        = 1'b0;
      i_funct3    = 3'd2;
      i_addr      = 32'h0000_0040;
      @(negedge i_clk);
      i_mem_gnt = 1'b1;
      @(negedge i_clk);
      i_mem_gnt = 1'b0;
      #1;
      chk("resp_stall", o_stall, 1'b1);
      i_reset = 1'b1;
      #1;
      chk("async_rst_wb", o_wback_state.pc, 32'h0);
      chk("async_rst_rw", o_wback_state.reg_write, 1'b0);
      chk("async_rst_req", o_mem_req, 1'b0);
      @(negedge i_clk);
      i_reset       = 1'b0;
      i_req_valid   = 1'b0;
      ms2.pc        = 32'hC0DE_0001;
      ms2.rd        = 5'd7;
      ms2.reg_write = 1'b1;
      ms2.mem_to_reg = 1'b0;
      ms2.alu_output = 32'h5A5A_1234;
      i_mem_state   = ms2;
      i_mem_rvalid  = 1'b1;
      i_mem_rdata   = 32'hFFFF_FFFF;
      #1;
      chk("stray_stall", o_stall, 1'b0);
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      #1;
      chk("stray_final", o_wback_state.final_out, ms2.alu_output);
      chk("stray_pc", o_wback_state.pc, ms2.pc);
      chk("stray_req", o_mem_req, 1'b0);

      // Randomized traffic against the byte model.
      for (int n = 0; n < 250; n++) begin
         we   = 1'($urandom);
         f3   = we ? st_f3[$urandom_range(0, 5)] : 3'($urandom);
         addr = ($urandom & 32'hFFFF_E000) |
                ($urandom_range(0, 1) ? $urandom_range(0, 31) : $urandom_range(0, 8191));
         if ($urandom_range(0, 3) == 0) g = $urandom_range(0, TIMEOUT - 1);
         else                            g = $urandom_range(0, 3);
         r = g + $urandom_range(0, TIMEOUT - 1 - g);
         if ($urandom_range(0, 29) == 0) begin
            g = we ? 99 : g;
            r = 99;
         end
         do_access(we, f3, addr, $urandom, g, r, fin);
         if ($urandom_range(0, 4) == 0) do_alu();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
